// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI-style bus between sram_axi_bridge (master) and the memory system (slave).
interface sram_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  arid, araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Serialises the core's fetch and data SRAM ports onto one single-beat AXI master, data first.
// Optional macro SRAM_AXI_POSTED_WRITE_EN: stores complete on AW+W acceptance instead of on bvalid.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_sram_en_i,
  input  logic [31:0]               inst_sram_addr_i,
  output logic [31:0]               inst_sram_rdata_o,
  output logic                      inst_stall_o,
  input  logic                      data_sram_en_i,
  input  logic [3:0]                data_sram_wen_i,
  input  logic [31:0]               data_sram_addr_i,
  input  logic [31:0]               data_sram_wdata_i,
  output logic [31:0]               data_sram_rdata_o,
  output logic                      data_stall_o,
  sram_axi_bridge_if.master         axi
);

`ifdef SRAM_AXI_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  state_e      state_q;
  logic        req_is_data_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        inst_done_q;
  logic        data_done_q;

  // Done flags live for exactly one cycle so the core sees stall low once, then advances.
  assign inst_stall_o      = inst_sram_en_i & ~inst_done_q;
  assign data_stall_o      = data_sram_en_i & ~data_done_q;
  assign inst_sram_rdata_o = inst_rdata_q;
  assign data_sram_rdata_o = data_rdata_q;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // Bus FSM with registered handshake outputs, latched request fields and per-port results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_is_data_q <= 1'b0;
      arid_q        <= 4'd0;
      araddr_q      <= 32'd0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= 32'd0;
      awvalid_q     <= 1'b0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      inst_rdata_q  <= 32'd0;
      data_rdata_q  <= 32'd0;
      inst_done_q   <= 1'b0;
      data_done_q   <= 1'b0;
    end else begin
      if (inst_done_q) begin
        inst_done_q <= 1'b0;
      end
      if (data_done_q) begin
        data_done_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (data_sram_en_i && !data_done_q) begin
            if (data_sram_wen_i != 4'd0) begin
              awaddr_q  <= data_sram_addr_i;
              wdata_q   <= data_sram_wdata_i;
              wstrb_q   <= data_sram_wen_i;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              araddr_q      <= data_sram_addr_i;
              arid_q        <= DATA_ID;
              req_is_data_q <= 1'b1;
              arvalid_q     <= 1'b1;
              state_q       <= ST_RD_ADDR;
            end
          end else if (inst_sram_en_i && !inst_done_q) begin
            araddr_q      <= inst_sram_addr_i;
            arid_q        <= INST_ID;
            req_is_data_q <= 1'b0;
            arvalid_q     <= 1'b1;
            state_q       <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // Beats tagged with another id are not ours; keep rready high and wait.
          if (axi.rvalid && (axi.rid == arid_q)) begin
            rready_q <= 1'b0;
            state_q  <= ST_IDLE;
            if (req_is_data_q) begin
              data_rdata_q <= axi.rdata;
              data_done_q  <= 1'b1;
            end else begin
              inst_rdata_q <= axi.rdata;
              inst_done_q  <= 1'b1;
            end
          end
        end
        ST_WR_REQ: begin
          if (awvalid_q && axi.awready) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && axi.wready) begin
            wvalid_q <= 1'b0;
          end
          if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
            if (POSTED) begin
              data_done_q <= 1'b1;
            end
          end
        end
        ST_WR_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_IDLE;
            if (!POSTED) begin
              data_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; the bench plays both the CPU core and the AXI slave.
module tb_sram_axi_bridge;

`ifdef SRAM_AXI_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_stall;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_stall;

  int checks;
  int errors;

  sram_axi_bridge_if bus ();

  sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_sram_en_i    (inst_sram_en),
    .inst_sram_addr_i  (inst_sram_addr),
    .inst_sram_rdata_o (inst_sram_rdata),
    .inst_stall_o      (inst_stall),
    .data_sram_en_i    (data_sram_en),
    .data_sram_wen_i   (data_sram_wen),
    .data_sram_addr_i  (data_sram_addr),
    .data_sram_wdata_i (data_sram_wdata),
    .data_sram_rdata_o (data_sram_rdata),
    .data_stall_o      (data_stall),
    .axi               (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
    inst_sram_en = 1'b0; inst_sram_addr = 32'd0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    chk("rst_rready", {31'd0, bus.rready}, 32'd0);
    chk("rst_awvalid", {31'd0, bus.awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, bus.wvalid}, 32'd0);
    chk("rst_bready", {31'd0, bus.bready}, 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_wstrb", {28'd0, bus.wstrb}, 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_data_rdata", data_sram_rdata, 32'd0);
    chk("rst_stalls", {30'd0, inst_stall, data_stall}, 32'd0);
    rst = 1'b0;

    // Fetch 0xBFC00000 with single-cycle slave
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000; bus.arready = 1'b1; #1;
    chk("f_c0_stall", {31'd0, inst_stall}, 32'd1);
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h3C1D_0001; #1;
    chk("f_c1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("f_c1_arid", {28'd0, bus.arid}, 32'd0);
    chk("f_c1_araddr", bus.araddr, 32'hBFC0_0000);
    chk("f_c1_stall", {31'd0, inst_stall}, 32'd1);
    @(negedge clk); #1;
    chk("f_c2_rready", {31'd0, bus.rready}, 32'd1);
    chk("f_c2_arvalid", {31'd0, bus.arvalid}, 32'd0);
    chk("f_c2_stall", {31'd0, inst_stall}, 32'd1);
    @(negedge clk);
    bus.rvalid = 1'b0; #1;
    chk("f_c3_stall", {31'd0, inst_stall}, 32'd0);
    chk("f_c3_rdata", inst_sram_rdata, 32'h3C1D_0001);
    inst_sram_en = 1'b0;

    // Simultaneous fetch 0x100 and load 0x2000: data goes first
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0100;
    data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h0000_2000; #1;
    chk("s_c0_stalls", {30'd0, inst_stall, data_stall}, 32'd3);
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hD0D0_0001; #1;
    chk("s_c1_arid", {28'd0, bus.arid}, 32'd1);
    chk("s_c1_araddr", bus.araddr, 32'h0000_2000);
    @(negedge clk); #1;
    chk("s_c2_stalls", {30'd0, inst_stall, data_stall}, 32'd3);
    @(negedge clk);
    bus.rvalid = 1'b0; #1;
    chk("s_c3_stalls", {30'd0, inst_stall, data_stall}, 32'd2);
    chk("s_c3_drdata", data_sram_rdata, 32'hD0D0_0001);
    data_sram_en = 1'b0;
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h1111_2222; #1;
    chk("s_c4_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("s_c4_arid", {28'd0, bus.arid}, 32'd0);
    chk("s_c4_araddr", bus.araddr, 32'h0000_0100);
    chk("s_c4_istall", {31'd0, inst_stall}, 32'd1);
    @(negedge clk); #1;
    chk("s_c5_istall", {31'd0, inst_stall}, 32'd1);
    @(negedge clk);
    bus.rvalid = 1'b0; #1;
    chk("s_c6_istall", {31'd0, inst_stall}, 32'd0);
    chk("s_c6_irdata", inst_sram_rdata, 32'h1111_2222);
    inst_sram_en = 1'b0;

    // Store 0x1234ABCD to 0x40, wen 0011, awready two cycles before wready
    @(negedge clk);
    bus.arready = 1'b0;
    data_sram_en = 1'b1; data_sram_wen = 4'b0011; data_sram_addr = 32'h0000_0040;
    data_sram_wdata = 32'h1234_ABCD; #1;
    chk("w_c0_stall", {31'd0, data_stall}, 32'd1);
    @(negedge clk);
    bus.awready = 1'b1; #1;
    chk("w_c1_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    chk("w_c1_awaddr", bus.awaddr, 32'h0000_0040);
    chk("w_c1_wdata", bus.wdata, 32'h1234_ABCD);
    chk("w_c1_wstrb", {28'd0, bus.wstrb}, 32'd3);
    @(negedge clk);
    bus.awready = 1'b0; #1;
    chk("w_c2_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
    chk("w_c2_stall", {31'd0, data_stall}, 32'd1);
    @(negedge clk);
    bus.wready = 1'b1; #1;
    chk("w_c3_wvalid", {31'd0, bus.wvalid}, 32'd1);
    chk("w_c3_wstrb", {28'd0, bus.wstrb}, 32'd3);
    @(negedge clk);
    bus.wready = 1'b0; #1;
    chk("w_c4_wvalid", {31'd0, bus.wvalid}, 32'd0);
    chk("w_c4_bready", {31'd0, bus.bready}, 32'd1);
    chk("w_c4_stall", {31'd0, data_stall}, {31'd0, !POSTED});
    if (POSTED) data_sram_en = 1'b0;
    @(negedge clk);
    bus.bvalid = 1'b1; #1;
    chk("w_c5_stall", {31'd0, data_stall}, {31'd0, !POSTED});
    chk("w_c5_bready", {31'd0, bus.bready}, 32'd1);
    @(negedge clk);
    bus.bvalid = 1'b0; #1;
    chk("w_c6_stall", {31'd0, data_stall}, 32'd0);
    chk("w_c6_bready", {31'd0, bus.bready}, 32'd0);
    chk("w_c6_drdata_kept", data_sram_rdata, 32'hD0D0_0001);
    data_sram_en = 1'b0; data_sram_wen = 4'd0;

    // Load from 0x3000 with a stray rid=3 beat and a 5-cycle delayed response
    @(negedge clk);
    bus.arready = 1'b1; data_sram_en = 1'b1; data_sram_addr = 32'h0000_3000; #1;
    chk("l_c0_stall", {31'd0, data_stall}, 32'd1);
    @(negedge clk); #1;
    chk("l_c1_arid", {28'd0, bus.arid}, 32'd1);
    chk("l_c1_araddr", bus.araddr, 32'h0000_3000);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      bus.rvalid = (c == 3 || c == 6);
      bus.rid    = (c == 3) ? 4'd3 : 4'd1;
      bus.rdata  = (c == 3) ? 32'hBAD0_BAD0 : 32'h600D_F00D;
      #1;
      chk("l_wait_stall", {31'd0, data_stall}, 32'd1);
      chk("l_wait_rready", {31'd0, bus.rready}, 32'd1);
    end
    @(negedge clk);
    bus.rvalid = 1'b0; #1;
    chk("l_c7_stall", {31'd0, data_stall}, 32'd0);
    chk("l_c7_drdata", data_sram_rdata, 32'h600D_F00D);
    data_sram_en = 1'b0;

    // Reset while waiting in RD_DATA
    @(negedge clk);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0200; #1;
    @(negedge clk); #1;
    chk("r_c1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    @(negedge clk);
    rst = 1'b1; data_sram_en = 1'b1; #1;
    chk("r_c2_rready", {31'd0, bus.rready}, 32'd1);
    @(negedge clk); #1;
    chk("r_c3_arvalid", {31'd0, bus.arvalid}, 32'd0);
    chk("r_c3_rready", {31'd0, bus.rready}, 32'd0);
    chk("r_c3_stalls", {30'd0, inst_stall, data_stall}, 32'd3);
    chk("r_c3_irdata", inst_sram_rdata, 32'd0);
    chk("r_c3_drdata", data_sram_rdata, 32'd0);
    rst = 1'b0; inst_sram_en = 1'b0; data_sram_en = 1'b0; #1;
    chk("r_c3_stalls_off", {30'd0, inst_stall, data_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
